// File: rtl/demux_dispatch_1x4.sv
// -----------------------------------------------------------------------------
// demux_dispatch_1x4
//
// Purpose:
//   Routes a single upstream valid/ready stream to one of four downstream
//   channels. Each channel is a one-entry register slice (payload + valid).
//   The destination comes either from the sel input or from an internal
//   round-robin pointer that advances on every accepted word while rr_en=1.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The sender holds data stable while valid=1 and ready=0. The receiver's
//   ready never depends on the sender's valid, so there is no comb loop.
//   A full channel that drains on the same edge accepts a new word, so a
//   continuously-ready consumer sees no bubbles.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous, active-high reset
//   data_in   in   WIDTH   upstream payload
//   sel       in   2       destination channel when rr_en=0
//   rr_en     in   1       1: destination = rr_ptr, 0: destination = sel
//   in_valid  in   1       upstream offers data_in
//   in_ready  out  1       addressed channel can take data_in this cycle
//   y_data    out  4*WIDTH channel i payload in [i*WIDTH +: WIDTH]
//   y_valid   out  4       per-channel valid
//   y_ready   in   4       per-channel downstream ready
//   rr_ptr    out  2       current round-robin pointer
// -----------------------------------------------------------------------------
module demux_dispatch_1x4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [1:0]           sel,
    input  logic                 rr_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   y_data,
    output logic [3:0]           y_valid,
    input  logic [3:0]           y_ready,
    output logic [1:0]           rr_ptr
);

    logic [4*WIDTH-1:0] data_q,   data_d;
    logic [3:0]         valid_q,  valid_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;

    logic [1:0]         dest;
    logic               in_fire;
    logic [3:0]         load;
    logic [3:0]         drain;

    // Destination is resolved every cycle so rr_en/sel may change freely.
    assign dest = rr_en ? rr_ptr_q : sel;

    // Only the addressed channel gates acceptance; a stalled neighbour does
    // not block traffic. Forced low during reset so nothing is accepted
    // while state is being cleared.
    assign in_ready = (~valid_q[dest] | y_ready[dest]) & ~rst;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        load     = 4'b0000;
        drain    = 4'b0000;
        valid_d  = valid_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;

        for (int i = 0; i < 4; i++) begin
            load[i]  = in_fire && (dest == 2'(i));
            drain[i] = valid_q[i] & y_ready[i];

            // Load wins over drain: a simultaneous drain+load keeps the
            // slot full with the new word (no bubble).
            if (load[i]) begin
                valid_d[i]                = 1'b1;
                data_d[i*WIDTH +: WIDTH]  = data_in;
            end else if (drain[i]) begin
                // Payload is left in place; only a load changes y_data.
                valid_d[i] = 1'b0;
            end
        end

        if (in_fire && rr_en) begin
            rr_ptr_d = rr_ptr_q + 2'd1;  // wraps 3 -> 0 naturally
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            valid_q  <= 4'b0000;
            rr_ptr_q <= 2'b00;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign y_data  = data_q;
    assign y_valid = valid_q;
    assign rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_demux_dispatch_1x4.sv
// -----------------------------------------------------------------------------
// tb_demux_dispatch_1x4
//
// Directed bench for demux_dispatch_1x4 (WIDTH=8). The driver pushes the
// hand-computed destination/payload of every accepted word into a
// per-channel expected queue; an independent monitor pops and compares on
// every downstream transfer. Directed point checks cover reset, routing,
// backpressure, round-robin order, addressed-only stall and async reset.
// -----------------------------------------------------------------------------
module tb_demux_dispatch_1x4;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0]   data_in  = '0;
    logic [1:0]     sel      = 2'b00;
    logic           rr_en    = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*W-1:0] y_data;
    logic [3:0]     y_valid;
    logic [3:0]     y_ready  = 4'b0000;
    logic [1:0]     rr_ptr;

    demux_dispatch_1x4 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .sel      (sel),
        .rr_en    (rr_en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .rr_ptr   (rr_ptr)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[4][$];
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every downstream transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (y_valid[i] && y_ready[i]) begin
                    compared++;
                    if (exp_q[i].size() == 0) begin
                        mismatched++;
                        $display("FAIL out_ch%0d: got %0h expected nothing", i, y_data[i*W +: W]);
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q[i].pop_front();
                        if (y_data[i*W +: W] !== e) begin
                            mismatched++;
                            $display("FAIL out_ch%0d: got %0h expected %0h", i, y_data[i*W +: W], e);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge (or mid-cycle); returns 1 ns after the
    // edge on which the word was transferred.
    task automatic send(input logic [W-1:0] d, input logic [1:0] s,
                        input logic rr, input int ch);
        int k;
        data_in  = d;
        sel      = s;
        rr_en    = rr;
        in_valid = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (!in_ready) begin
            mismatched++;
            $display("FAIL send_%0h: got in_ready=0 expected acceptance within 50 cycles", d);
        end else begin
            exp_q[ch].push_back(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Hard guard so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [1:0] rr_exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] rr_exp_ptr[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        // Reset state
        #2;
        check("rst_y_valid",  32'(y_valid),  32'h0);
        check("rst_y_data",   y_data,        32'h0);
        check("rst_rr_ptr",   32'(rr_ptr),   32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // sel routing, all ready
        y_ready = 4'b1111;
        send(8'hA5, 2'd2, 1'b0, 2);
        check("route_y_valid", 32'(y_valid),        32'b0100);
        check("route_slice2",  32'(y_data[23:16]),  32'hA5);
        @(posedge clk); #1;
        check("route_drained", 32'(y_valid),        32'h0);

        // Backpressure on channel 1
        y_ready = 4'b0000;
        send(8'h11, 2'd1, 1'b0, 1);
        check("bp_valid1",   32'(y_valid[1]), 32'h1);
        check("bp_in_ready", 32'(in_ready),   32'h0);
        data_in  = 8'h22;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_stall_ready", 32'(in_ready),     32'h0);
            check("bp_hold_slice1", 32'(y_data[15:8]), 32'h11);
        end
        @(posedge clk); #1;
        y_ready = 4'b0010;
        send(8'h22, 2'd1, 1'b0, 1);
        check("bp_no_bubble", 32'(y_valid[1]),   32'h1);
        check("bp_new_slice", 32'(y_data[15:8]), 32'h22);
        y_ready = 4'b1111;
        @(posedge clk); #1;

        // Round-robin: sel deliberately disagrees to prove it is ignored
        check("rr_start", 32'(rr_ptr), 32'h0);
        for (int i = 0; i < 5; i++) begin
            send(W'(i + 1), 2'd3 - rr_exp_ch[i], 1'b1, int'(rr_exp_ch[i]));
            check("rr_ptr",     32'(rr_ptr),  32'(rr_exp_ptr[i]));
            check("rr_y_valid", 32'(y_valid), 32'(4'b0001 << rr_exp_ch[i]));
        end
        @(posedge clk); #1;

        // Addressed-only stall
        y_ready = 4'b0111;
        send(8'h33, 2'd3, 1'b0, 3);
        send(8'h44, 2'd0, 1'b0, 0);
        check("stall_rr_hold", 32'(rr_ptr), 32'h1);
        data_in  = 8'h55;
        sel      = 2'd3;
        in_valid = 1'b1;
        @(negedge clk);
        check("stall_ch3_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        sel      = 2'd0;
        #1;
        check("stall_ch0_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        check("stall_ch3_kept", 32'(y_data[31:24]), 32'h33);

        // Build y_valid=1011, rr_ptr=2, then async reset mid-cycle
        y_ready = 4'b0000;
        send(8'h66, 2'd0, 1'b1, 1);
        send(8'h77, 2'd0, 1'b0, 0);
        check("pre_rst_valid", 32'(y_valid), 32'b1011);
        check("pre_rst_ptr",   32'(rr_ptr),  32'h2);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("async_y_valid",  32'(y_valid),  32'h0);
        check("async_rr_ptr",   32'(rr_ptr),   32'h0);
        check("async_in_ready", 32'(in_ready), 32'h0);
        check("async_y_data",   y_data,        32'h0);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        #1;
        rst = 1'b0;
        y_ready = 4'b1111;
        send(8'h88, 2'd2, 1'b1, 0);
        check("post_rst_valid", 32'(y_valid),      32'b0001);
        check("post_rst_slice", 32'(y_data[7:0]),  32'h88);
        check("post_rst_ptr",   32'(rr_ptr),       32'h1);

        // Everything sent must have come out
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("queue_empty", 32'(exp_q[i].size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_1x4.md
DEMUX_DISPATCH_1X4 -- requirements
Module: demux_dispatch_1x4

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the payload width in bits.
REQ-002 The block SHALL have the following ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  payload offered upstream.
- sel  input  2  destination channel when rr_en=0.
- rr_en  input  1  1 = round-robin destination from rr_ptr; 0 = destination from sel.
- in_valid  input  1  upstream offers data_in.
- in_ready  output  1  block accepts data_in this cycle.
- y_data  output  4*WIDTH  channel i payload in bits [i*WIDTH +: WIDTH].
- y_valid  output  4  per-channel output valid.
- y_ready  input  4  per-channel downstream ready.
- rr_ptr  output  2  current round-robin pointer.
REQ-003 Clock and reset SHALL be exactly as stated above: one clock; reset is asynchronous and active-high.

Function
REQ-004 dest SHALL be defined as rr_ptr when rr_en=1, else sel.
REQ-005 Each channel SHALL hold exactly one entry: a WIDTH-bit payload register plus its y_valid bit.
REQ-006 in_ready SHALL be combinational: (~y_valid[dest] | y_ready[dest]) & ~rst.
- It SHALL depend only on the addressed channel.
REQ-007 An input transfer SHALL occur when in_valid & in_ready. On that edge:
- y_data slice dest SHALL load data_in.
- y_valid[dest] SHALL become 1.
- Latency from input transfer to y_valid: exactly 1 cycle.
REQ-008 An output transfer on channel i SHALL occur when y_valid[i] & y_ready[i]. On that edge y_valid[i] SHALL clear, unless REQ-009 applies.
REQ-009 When channel dest drains and loads in the same cycle:
- y_valid[dest] SHALL stay 1.
- y_data slice dest SHALL take the new data_in.
- No bubble SHALL be inserted.
REQ-010 While y_valid[i]=1 and y_ready[i]=0, the y_data slice i SHALL hold its value unchanged.
REQ-011 A slice with y_valid[i]=0 SHALL retain its last value; y_data changes only on a load.
REQ-012 Channels other than dest SHALL be unaffected by the input transfer.
- Each channel's output handshake SHALL be independent; multiple channels may drain in the same cycle.
REQ-013 When channel dest is full and not draining, in_ready SHALL be 0. Data SHALL never be overwritten or dropped.
REQ-014 in_valid with in_ready=0 SHALL cause no state change.
REQ-015 rr_ptr SHALL increment modulo 4 (3 -> 0) on each input transfer while rr_en=1.
- It SHALL hold otherwise, including when rr_en=0.
REQ-016 rr_en and sel MAY change on any cycle; dest is evaluated in the cycle of the transfer.
REQ-017 Channel mapping SHALL match the downstream demux_1x4 bit order: sel=2'b00 -> channel 0 ... sel=2'b11 -> channel 3.

Reset
REQ-018 When rst asserts, the block SHALL immediately (without waiting for a clock edge) set:
- y_valid = 4'b0000
- y_data = 0
- rr_ptr = 2'b00
- in_ready = 0
REQ-019 Entries held when reset asserts mid-operation SHALL be discarded.
REQ-020 After rst deasserts, the first rising edge of clk SHALL be able to accept a transfer.

Verification
REQ-021 Directed sel routing, rr_en=0, all y_ready=1:
- Send 8'hA5 with sel=2 -> next cycle y_valid=4'b0100 and slice 2 = 8'hA5.
- Following cycle y_valid=0.
REQ-022 Backpressure, rr_en=0, sel=1, y_ready=0:
- Send 8'h11 -> y_valid[1]=1, then in_ready=0.
- Offer 8'h22 for 3 cycles -> slice 1 stays 8'h11.
- Raise y_ready[1] -> 8'h22 loads that edge and y_valid[1] stays 1 (no bubble).
REQ-023 Round-robin, rr_en=1, y_ready=4'b1111:
- Send 5 words 1..5 -> they appear on channels 0,1,2,3,0.
- rr_ptr sequence 0,1,2,3,0,1.
REQ-024 Addressed-only stall, rr_en=0:
- Fill channel 3 with y_ready[3]=0.
- Send to channel 0 -> accepted, in_ready=1.
- Send to channel 3 -> in_ready=0.
REQ-025 Reset mid-operation:
- With y_valid=4'b1011 and rr_ptr=2, assert rst between clock edges.
- Required: y_valid=0, rr_ptr=0, in_ready=0 with no clock edge; after release, the next transfer lands on channel 0 when rr_en=1.
